pkt_pad_ctrl: RTL
=================

// Module: pkt_pad_ctrl
// PURPOSE
//  Padding controller that sits directly upstream of the packet mux stage.
//  - Passes message packets through unchanged.
//  - After the last message packet, sequences exactly one pad packet, then zero
//    packets, then a final length packet, so the message ends block-aligned.
//  - Drives the mux selects pad_pkt / zero_pkt / mgln_pkt and the msg_len value.
// PARAMETERS
//  w     64  packet width in bits; msg_len counter width
//  nblk  8   packets per block (>=2); the length packet always occupies slot nblk-1
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        upstream message packet available
//  in_last    in   1        qualifies in_valid: this is the final message packet
//  in_ready   out  1        controller accepts a message packet this cycle
//  out_ready  in   1        downstream (mux consumer) accepts a packet this cycle
//  out_valid  out  1        a packet slot is presented downstream
//  pad_pkt    out  1        current slot is the pad packet
//  zero_pkt   out  1        current slot is a zero packet
//  mgln_pkt   out  1        current slot is the length packet
//  msg_len    out  w        message length in bits (packets accepted * w)
//  blk_end    out  1        out_valid && slot index == nblk-1
//  done       out  1        one-cycle pulse: message fully emitted
// BEHAVIOUR
//  Registered state: state {MSG, PAD, ZERO, LEN}, slot idx (0..nblk-1), len (w bits), done.
//  Handshake and outputs:
//  - A transfer occurs when out_valid && out_ready.
//  - idx <= (idx==nblk-1) ? 0 : idx+1 on every transfer.
//  - All outputs are combinational from registered state, except done (registered).
//  Reset (rst=1 at clk edge, regardless of state):
//  - state=MSG, idx=0, len=0, done=0.
//  - Any in-flight pad, zero or length sequence is abandoned.
//  - After reset: pad_pkt = zero_pkt = mgln_pkt = 0, msg_len = 0.
//  MSG:
//  - in_ready = out_ready; out_valid = in_valid; all selects 0.
//  - On transfer: len <= len + w (wraps modulo 2^w).
//  - If in_last on that transfer: go to PAD.
//  PAD:
//  - out_valid=1, pad_pkt=1, in_ready=0.
//  - On transfer: go to LEN if the next idx == nblk-1, else go to ZERO.
//  - A pad landing in slot nblk-1 therefore forces one full extra block of
//    zeros (slots 0..nblk-2) before the length packet.
//  ZERO:
//  - out_valid=1, zero_pkt=1, in_ready=0.
//  - On transfer: go to LEN when the next idx == nblk-1.
//  LEN:
//  - out_valid=1, mgln_pkt=1, in_ready=0; msg_len=len.
//  - On transfer: done <= 1 for exactly one cycle; state=MSG, idx=0, len=0.
//  - The next message may be accepted in the cycle after the LEN transfer.
//  Other rules:
//  - msg_len = len in every state; the value is valid for sampling in LEN.
//  - out_ready low in any state: state, idx, len and all outputs hold.
//  - in_last without in_valid is ignored.
//  - Latency: 0 cycles for message packets (combinational pass-through).
//    1 + zeros + 1 slots of padding follow the last message packet.
// CONFIGURATION
//  PKT_PAD_BLKCNT_EN
//  - Defined: adds output blk_cnt [15:0], the number of completed blocks
//    (increments on each transfer with blk_end=1, wraps at 2^16).
//    blk_cnt is cleared by rst only, not by done.
//  - Not defined: the port and its counter are absent; all other behaviour is identical.
// TESTING (w=64, nblk=8)
//  1 3 pkts, in_last on 3rd, out_ready=1 -> pad@slot3, zero@4-6, mgln@7 with
//    msg_len=0xC0; done=1 one cycle later.
//  2 6 pkts -> pad@6, mgln@7 with msg_len=0x180; zero_pkt never asserted.
//  3 8 pkts -> pad@slot0 of block 2, zero@1-6, mgln@7 with msg_len=0x200;
//    blk_end seen twice.
//  4 7 pkts -> pad@7, zero@0-6 of block 2, mgln@7 with msg_len=0x1C0.
//  5 out_ready=0 for 3 cycles mid-ZERO -> selects, idx and msg_len stable;
//    sequence resumes unchanged.
//  6 rst=1 for one cycle during ZERO -> next cycle state MSG, msg_len=0, all selects 0;
//    a new 2-pkt message then pads normally (mgln@7, msg_len=0x80).

Source files
------------

// File: rtl/pkt_pad_ctrl.sv
// Pads a message out to a block boundary: one pad, zero fill, then the length packet.
// Define PKT_PAD_BLKCNT_EN to add the blk_cnt completed-block counter output.
module pkt_pad_ctrl #(
   parameter int w    = 64,
   parameter int nblk = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   input  logic         out_ready,
   output logic         out_valid,
   output logic         pad_pkt,
   output logic         zero_pkt,
   output logic         mgln_pkt,
   output logic [w-1:0] msg_len,
   output logic         blk_end,
`ifdef PKT_PAD_BLKCNT_EN
   output logic [15:0]  blk_cnt,
`endif
   output logic         done
);

   localparam int IW = (nblk > 2) ? $clog2(nblk) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(nblk - 1);
   localparam logic [w-1:0]  LEN_INC  = w'(w);

   localparam logic [1:0] S_MSG  = 2'd0;
   localparam logic [1:0] S_PAD  = 2'd1;
   localparam logic [1:0] S_ZERO = 2'd2;
   localparam logic [1:0] S_LEN  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_inc;
   logic [w-1:0]  len;
   logic          at_last;
   logic          nxt_last;
   logic          xfer;

   always_comb begin
      at_last  = (idx == LAST_IDX);
      idx_inc  = at_last ? '0 : idx + IW'(1);
      nxt_last = (idx_inc == LAST_IDX);
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      pad_pkt   = 1'b0;
      zero_pkt  = 1'b0;
      mgln_pkt  = 1'b0;
      unique case (state)
         S_MSG: begin
            in_ready  = out_ready;
            out_valid = in_valid;
         end
         S_PAD: begin
            out_valid = 1'b1;
            pad_pkt   = 1'b1;
         end
         S_ZERO: begin
            out_valid = 1'b1;
            zero_pkt  = 1'b1;
         end
         S_LEN: begin
            out_valid = 1'b1;
            mgln_pkt  = 1'b1;
         end
         default: ;
      endcase
   end

   assign xfer    = out_valid & out_ready;
   assign msg_len = len;
   assign blk_end = out_valid & at_last;

   // A pad in the last slot leaves no room for the length packet, so it
   // falls through to ZERO and fills a whole extra block.
   always_comb begin
      state_nxt = state;
      if (xfer) begin
         unique case (state)
            S_MSG:   if (in_last) state_nxt = S_PAD;
            S_PAD:   state_nxt = nxt_last ? S_LEN : S_ZERO;
            S_ZERO:  if (nxt_last) state_nxt = S_LEN;
            S_LEN:   state_nxt = S_MSG;
            default: state_nxt = S_MSG;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_MSG;
         idx   <= '0;
         len   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= xfer && (state == S_LEN);
         if (xfer) begin
            idx <= (state == S_LEN) ? '0 : idx_inc;
            if (state == S_MSG)
               len <= len + LEN_INC;
            else if (state == S_LEN)
               len <= '0;
         end
      end
   end

`ifdef PKT_PAD_BLKCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         blk_cnt <= '0;
      else if (xfer && at_last)
         blk_cnt <= blk_cnt + 16'd1;
   end
`endif

endmodule
